// File: rtl/vga_sync_gen.sv
// VGA raster timing: hsync/vsync, video_on, pixel coordinates, line/frame ticks.
// Outputs register on the same pix_en edge as px_x/px_y (zero skew); pix_en=0 freezes everything.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] px_x,
   output logic [CNT_W-1:0] px_y,
   output logic             line_tick,
   output logic             frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
         $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
      end
   endgenerate

   localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_FP_START   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_BP_START   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_FP_START   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_BP_START   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_e;

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   phase_e           hphase_q, hphase_d;
   phase_e           vphase_q, vphase_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             line_tick_q, line_tick_d;
   logic             frame_tick_q, frame_tick_d;
   logic             x_wrap, y_wrap;

   // Phase advances when the counter lands on the first position of the next phase.
   function automatic phase_e next_phase(input phase_e cur,
                                         input logic [CNT_W-1:0] nxt,
                                         input logic [CNT_W-1:0] fp_start,
                                         input logic [CNT_W-1:0] sync_start,
                                         input logic [CNT_W-1:0] bp_start);
      phase_e res;
      res = cur;
      case (cur)
         PH_ACTIVE: if (nxt == fp_start)   res = PH_FP;
         PH_FP:     if (nxt == sync_start) res = PH_SYNC;
         PH_SYNC:   if (nxt == bp_start)   res = PH_BP;
         PH_BP:     if (nxt == '0)         res = PH_ACTIVE;
         default:   res = cur;
      endcase
      return res;
   endfunction

   always_comb begin
      x_wrap       = (x_q == H_LAST);
      y_wrap       = (y_q == V_LAST);
      x_d          = x_q;
      y_d          = y_q;
      hphase_d     = hphase_q;
      vphase_d     = vphase_q;
      line_tick_d  = 1'b0;
      frame_tick_d = 1'b0;
      if (pix_en) begin
         x_d         = x_wrap ? '0 : x_q + CNT_W'(1);
         line_tick_d = x_wrap;
         hphase_d    = next_phase(hphase_q, x_d, H_FP_START, H_SYNC_START, H_BP_START);
         if (x_wrap) begin
            y_d          = y_wrap ? '0 : y_q + CNT_W'(1);
            frame_tick_d = y_wrap;
            vphase_d     = next_phase(vphase_q, y_d, V_FP_START, V_SYNC_START, V_BP_START);
         end
      end
      // Decoded from next-state values so the registered syncs line up with px_x/px_y.
      hsync_d    = (hphase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d    = (vphase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_d = (x_d < H_FP_START) && (y_d < V_FP_START);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q          <= H_LAST;
         y_q          <= V_LAST;
         hphase_q     <= PH_BP;
         vphase_q     <= PH_BP;
         hsync_q      <= ~SYNC_POL;
         vsync_q      <= ~SYNC_POL;
         video_on_q   <= 1'b0;
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         hphase_q     <= hphase_d;
         vphase_q     <= vphase_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         video_on_q   <= video_on_d;
         line_tick_q  <= line_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign px_x       = x_q;
   assign px_y       = y_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = video_on_q;
   assign line_tick  = line_tick_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance plus a shrunken raster (15x11,
// active-high sync) so whole frames fit in a short run. Reference model feeds a scoreboard.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic rst;
   logic pix_en;

   logic       b_hs, b_vs, b_von, b_lt, b_ft;
   logic [9:0] b_x, b_y;
   logic       s_hs, s_vs, s_von, s_lt, s_ft;
   logic [3:0] s_x, s_y;

   always #5 clk = ~clk;

   vga_sync_gen u_big (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
      .px_x(b_x), .px_y(b_y), .line_tick(b_lt), .frame_tick(b_ft)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b1), .CNT_W(4)
   ) u_small (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
      .px_x(s_x), .px_y(s_y), .line_tick(s_lt), .frame_tick(s_ft)
   );

   // Model parameters: index 0 = big instance, 1 = small instance.
   int ha[2]  = '{640, 8};
   int hf[2]  = '{16, 2};
   int hsw[2] = '{96, 3};
   int hb[2]  = '{48, 2};
   int va[2]  = '{480, 6};
   int vf[2]  = '{10, 1};
   int vsw[2] = '{2, 2};
   int vb[2]  = '{33, 2};
   bit pol[2] = '{1'b0, 1'b1};
   int mx[2];
   int my[2];

   logic [31:0] q_big[$];
   logic [31:0] q_small[$];

   int checks   = 0;
   int failures = 0;

   // Observed-side statistics, gathered from DUT outputs.
   int b_since_lt = 0, b_period = 0, b_hs_cnt = 0, b_hs_last = 0, b_von_cnt = 0, b_von_last = 0;
   int s_since_ft = 0, s_period = 0, s_vs_cnt = 0, s_vs_last = 0, s_von_cnt = 0, s_von_last = 0;
   int s_since_lt = 0, s_lperiod = 0;
   int bad_von = 0;
   int tick_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int htot(int d);
      return ha[d] + hf[d] + hsw[d] + hb[d];
   endfunction

   function automatic int vtot(int d);
      return va[d] + vf[d] + vsw[d] + vb[d];
   endfunction

   function automatic logic [31:0] pack_exp(int d, bit lt, bit ft);
      int  xs, ys;
      bit  hs, vs, von;
      logic [9:0] xv, yv;
      xs  = ha[d] + hf[d];
      ys  = va[d] + vf[d];
      hs  = (mx[d] >= xs && mx[d] < xs + hsw[d]) ? pol[d] : ~pol[d];
      vs  = (my[d] >= ys && my[d] < ys + vsw[d]) ? pol[d] : ~pol[d];
      von = (mx[d] < ha[d]) && (my[d] < va[d]);
      xv  = mx[d][9:0];
      yv  = my[d][9:0];
      return {7'b0, xv, yv, hs, vs, von, lt, ft};
   endfunction

   function automatic logic [31:0] obs_big();
      return {7'b0, b_x, b_y, b_hs, b_vs, b_von, b_lt, b_ft};
   endfunction

   function automatic logic [31:0] obs_small();
      return {7'b0, 6'b0, s_x, 6'b0, s_y, s_hs, s_vs, s_von, s_lt, s_ft};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mx[d] = htot(d) - 1;
         my[d] = vtot(d) - 1;
      end
   endtask

   task automatic model_step(input int d, input bit en, output bit lt, output bit ft);
      lt = 1'b0;
      ft = 1'b0;
      if (en) begin
         if (mx[d] == htot(d) - 1) begin
            mx[d] = 0;
            lt    = 1'b1;
            if (my[d] == vtot(d) - 1) begin
               my[d] = 0;
               ft    = 1'b1;
            end else begin
               my[d] = my[d] + 1;
            end
         end else begin
            mx[d] = mx[d] + 1;
         end
      end
   endtask

   task automatic update_stats();
      if (b_lt) begin
         b_period = b_since_lt; b_since_lt = 1;
         b_hs_last = b_hs_cnt;  b_hs_cnt = (b_hs == 1'b0) ? 1 : 0;
         b_von_last = b_von_cnt; b_von_cnt = b_von ? 1 : 0;
      end else begin
         b_since_lt++;
         if (b_hs == 1'b0) b_hs_cnt++;
         if (b_von) b_von_cnt++;
      end
      if (s_ft) begin
         s_period = s_since_ft; s_since_ft = 1;
         s_vs_last = s_vs_cnt;  s_vs_cnt = s_vs ? 1 : 0;
         s_von_last = s_von_cnt; s_von_cnt = s_von ? 1 : 0;
      end else begin
         s_since_ft++;
         if (s_vs) s_vs_cnt++;
         if (s_von) s_von_cnt++;
      end
      if (s_lt) begin
         s_lperiod = s_since_lt; s_since_lt = 1;
      end else begin
         s_since_lt++;
      end
      if (b_von && (b_x >= 10'd640 || b_y >= 10'd480)) bad_von++;
      if (s_von && (s_x >= 4'd8 || s_y >= 4'd6)) bad_von++;
      if (b_lt || b_ft || s_lt || s_ft) tick_seen++;
   endtask

   // One clock: drive pix_en, push the model's post-edge outputs, then compare after the edge.
   task automatic tick(input bit en);
      bit lt, ft;
      logic [31:0] e;
      @(negedge clk);
      pix_en = en;
      model_step(0, en, lt, ft);
      q_big.push_back(pack_exp(0, lt, ft));
      model_step(1, en, lt, ft);
      q_small.push_back(pack_exp(1, lt, ft));
      @(posedge clk);
      #1;
      e = q_big.pop_front();
      chk("sb_big", obs_big(), e);
      e = q_small.pop_front();
      chk("sb_small", obs_small(), e);
      update_stats();
   endtask

   initial begin
      int guard;
      rst    = 1'b1;
      pix_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_big", obs_big(), pack_exp(0, 1'b0, 1'b0));
      chk("rst_small", obs_small(), pack_exp(1, 1'b0, 1'b0));
      chk("rst_hsync_level", {31'b0, b_hs}, 32'd1);
      rst = 1'b0;

      // pix_en every 4th clk
      repeat (3) tick(1'b0);
      tick(1'b1);
      chk("first_xy", {12'b0, b_x, b_y}, 32'd0);
      chk("first_flags", {29'b0, b_von, b_lt, b_ft}, 32'd7);
      tick(1'b0);
      chk("tick_one_clk", {30'b0, b_lt, b_ft}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         repeat (3) tick(1'b0);
         tick(1'b1);
      end

      // continuous pix_en
      repeat (3000) tick(1'b1);
      chk("line_period", b_period, 32'd800);
      chk("hsync_low_clks", b_hs_last, 32'd96);
      chk("von_per_line", b_von_last, 32'd640);
      chk("small_line_period", s_lperiod, 32'd15);
      chk("small_frame_period", s_period, 32'd165);
      chk("small_vsync_clks", s_vs_last, 32'd30);
      chk("small_von_per_frame", s_von_last, 32'd48);
      chk("von_outside_area", bad_von, 32'd0);

      // run to (123,45), then freeze
      guard = 0;
      while (!(mx[0] == 123 && my[0] == 45) && guard < 60000) begin
         tick(1'b1);
         guard++;
      end
      chk("reach_freeze_xy", {12'b0, b_x, b_y}, {12'b0, 10'd123, 10'd45});
      tick_seen = 0;
      repeat (1000) tick(1'b0);
      chk("freeze_no_ticks", tick_seen, 32'd0);
      chk("freeze_xy", {12'b0, b_x, b_y}, {12'b0, 10'd123, 10'd45});
      chk("freeze_von", {31'b0, b_von}, 32'd1);

      // async reset between edges at column 300
      guard = 0;
      while (mx[0] != 300 && guard < 1000) begin
         tick(1'b1);
         guard++;
      end
      chk("pre_arst_x", {22'b0, b_x}, 32'd300);
      @(posedge clk);
      #3;
      pix_en = 1'b0;
      rst    = 1'b1;
      model_reset();
      #1;
      chk("arst_big", obs_big(), pack_exp(0, 1'b0, 1'b0));
      chk("arst_small", obs_small(), pack_exp(1, 1'b0, 1'b0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick(1'b1);
      chk("restart_xy", {12'b0, b_x, b_y}, 32'd0);
      chk("restart_ticks", {30'b0, b_lt, b_ft}, 32'd3);
      repeat (20) tick(1'b1);
      chk("after_restart_x", {22'b0, b_x}, 32'd20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
